// File: rtl/wb_uart_tx_fifo_if.sv
// rtl/wb_uart_tx_fifo_if.sv - Wishbone slave bus bundle for the buffered UART transmitter.
interface wb_uart_tx_fifo_if;
    logic [15:0] wb_adr_i;
    logic [7:0]  wb_dat_i;
    logic [7:0]  wb_dat_o;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_uart_tx_fifo.sv
// rtl/wb_uart_tx_fifo.sv - Wishbone byte FIFO feeding an 8N1 serial transmitter.
// Optional irq output is built when WB_UART_TX_IRQ_EN is defined.
module wb_uart_tx_fifo #(
    parameter logic [15:0] BASE_ADDR    = 16'h0100,
    parameter int          CLKS_PER_BIT = 234,
    parameter int          FIFO_AW      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_uart_tx_fifo_if.slave     wb,
`ifdef WB_UART_TX_IRQ_EN
    output logic                 irq,
`endif
    output logic                 uart_txd
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]    BAUD_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t               r_state, w_state_nxt;
    logic [7:0]           r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [FIFO_AW:0]     r_level;
    logic                 r_overflow, r_tx_enable, r_ack, r_txd;
    logic [7:0]           r_dat_o, r_shift;
    logic [CW-1:0]        r_baud;
    logic [2:0]           r_bit_idx;

    logic                 w_sel, w_access, w_wr, w_push_req, w_push_ok, w_ovf_set;
    logic                 w_ctrl_wr, w_flush, w_clr_ovf, w_pop, w_empty, w_full, w_busy;
    logic                 w_baud_end, w_txd, w_irq_en_rd;
    logic [1:0]           w_off;
    logic [7:0]           w_rdata, w_shift_nxt;
    logic [CW-1:0]        w_baud_nxt;
    logic [2:0]           w_bit_nxt;

    assign w_sel      = wb.wb_cyc_i & wb.wb_stb_i & (wb.wb_adr_i[15:2] == BASE_ADDR[15:2]);
    assign w_access   = w_sel & ~r_ack;
    assign w_wr       = w_access & wb.wb_we_i;
    assign w_off      = wb.wb_adr_i[1:0];
    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == FULL_LVL);
    assign w_busy     = (r_state != S_IDLE);

    // A push into a full FIFO still lands when the transmitter pops on the same edge.
    assign w_push_req = w_wr & (w_off == 2'd0);
    assign w_push_ok  = w_push_req & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & w_full & ~w_pop;
    assign w_clr_ovf  = w_wr & (w_off == 2'd1) & wb.wb_dat_i[3];
    assign w_ctrl_wr  = w_wr & (w_off == 2'd3);
    assign w_flush    = w_ctrl_wr & wb.wb_dat_i[1];

    always_comb begin
        w_rdata = 8'h00;
        case (w_off)
            2'd1:    w_rdata = {4'b0, r_overflow, w_busy, w_empty, w_full};
            2'd2:    w_rdata = 8'(r_level);
            2'd3:    w_rdata = {5'b0, w_irq_en_rd, 1'b0, r_tx_enable};
            default: w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack       <= 1'b0;
            r_dat_o     <= 8'h00;
            r_overflow  <= 1'b0;
            r_tx_enable <= 1'b1;
        end else begin
            r_ack <= w_sel & ~r_ack;
            if (w_access)
                r_dat_o <= w_rdata;
            if (w_ovf_set)
                r_overflow <= 1'b1;
            else if (w_clr_ovf)
                r_overflow <= 1'b0;
            if (w_ctrl_wr)
                r_tx_enable <= wb.wb_dat_i[0];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= wb.wb_dat_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok & ~w_pop)
                r_level <= r_level + 1'b1;
            else if (~w_push_ok & w_pop)
                r_level <= r_level - 1'b1;
        end
    end

    assign w_baud_end = (r_baud == BAUD_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        w_txd       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                if (r_tx_enable & ~w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_txd = 1'b0;
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            S_DATA: begin
                w_txd = r_shift[0];
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7)
                        w_state_nxt = S_STOP;
                    else
                        w_bit_nxt = r_bit_idx + 1'b1;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The line level is registered, so it trails the state by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_txd     <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_txd     <= w_txd;
        end
    end

`ifdef WB_UART_TX_IRQ_EN
    logic r_irq_en, r_irq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr)
                r_irq_en <= wb.wb_dat_i[2];
            r_irq <= (r_irq_en & w_empty & ~w_busy) | r_overflow;
        end
    end

    assign w_irq_en_rd = r_irq_en;
    assign irq         = r_irq;
`else
    assign w_irq_en_rd = 1'b0;
`endif

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_dat_o = r_dat_o;
    assign uart_txd    = r_txd;
endmodule

// File: doc/wb_uart_tx_fifo.md
Name: wb_uart_tx_fifo

Overview:
- Wishbone slave peripheral that sits directly downstream of the SPI-to-Wishbone bridge master.
- Byte writes to a 4-register window are buffered in a FIFO and shifted out as 8N1 serial on a TX pin.
- Status and fill-level registers are readable.
- Gives the host a buffered debug/console UART reachable over the SPI→Wishbone path.

Parameters:
- BASE_ADDR, 16'h0100, window base; decode on adr[15:2] == BASE_ADDR[15:2].
- CLKS_PER_BIT, 234, clk cycles per serial bit (27 MHz / 115200).
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wb_adr_i  in  16  Wishbone address
- wb_dat_i  in  8  Wishbone write data
- wb_dat_o  out  8  Wishbone read data
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  cycle
- wb_stb_i  in  1  strobe
- wb_ack_o  out  1  acknowledge
- uart_txd  out  1  serial output, idle high

Behaviour:
- Reset values: wb_ack_o=0, wb_dat_o=0, uart_txd=1, FIFO empty, overflow=0, tx_enable=1, irq_en=0, TX FSM=IDLE, baud/bit counters=0. Reset mid-frame: uart_txd returns high asynchronously and the frame is abandoned.
- Select: sel = cyc & stb & (adr[15:2]==BASE_ADDR[15:2]). Unselected accesses are never acked.
- Ack: wb_ack_o <= sel & !wb_ack_o. Ack is registered, rises 1 cycle after sel, and is high exactly 1 cycle. Back-to-back held strobes are acked every other cycle.
- Timing: write side-effects occur on the clock edge that raises ack. wb_dat_o is loaded on the same edge and is valid while ack is high. It holds its value otherwise.
- Register map, offset = adr[1:0]:
  - 0 DATA:
    - W: push byte. If FIFO full and no pop this cycle, the byte is dropped and overflow is set sticky.
    - R: 8'h00.
  - 1 STATUS:
    - R: {4'b0, overflow, tx_busy, empty, full}.
    - W: bit3=1 clears overflow; other bits ignored.
  - 2 COUNT:
    - R: {3'b0, level[4:0]}, range 0..16.
    - W: ignored.
  - 3 CTRL:
    - R/W: bit0 tx_enable, bit1 flush, bit2 irq_en; reads of bit1 return 0.
    - flush is self-clearing: on write, the FIFO empties and level=0 on the same edge.
    - A frame already in the shifter completes.
- FIFO:
  - Circular, wr_ptr/rd_ptr of FIFO_AW bits that wrap modulo depth.
  - level is FIFO_AW+1 bits.
  - Simultaneous push and pop: both occur and level is unchanged. This includes the full case; the push is accepted and overflow is not set.
  - Push and flush in the same cycle is impossible (different offsets).
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: if tx_enable & !empty → pop into shift register, go START. uart_txd=1.
  - START: uart_txd=0 for CLKS_PER_BIT cycles → DATA, bit_idx=0.
  - DATA: uart_txd=shift[0], LSB first, each bit CLKS_PER_BIT cycles; after bit 7 → STOP.
  - STOP: uart_txd=1 for CLKS_PER_BIT cycles → IDLE. The next pop may occur on the following cycle, so frames are back-to-back and gapless apart from one IDLE cycle.
  - Clearing tx_enable mid-frame completes the current frame, then holds in IDLE.
- tx_busy = (state != IDLE).
- Frame length: 10*CLKS_PER_BIT cycles.
- Pop-to-start-edge latency: uart_txd falls 1 cycle after the pop edge.

Optional Feature:
- Macro WB_UART_TX_IRQ_EN.
- Defined: adds output port irq (1 bit, reset 0), registered. irq = irq_en & empty & !tx_busy, i.e. asserted when all data has drained, and also when overflow=1 regardless of irq_en. CTRL bit2 is writable.
- Undefined: no irq port; CTRL bit2 reads 0 and writes to it are ignored.

Test Plan:
- Write 8'h55 to 16'h0100 → ack 1 cycle after stb, exactly 1 cycle wide. uart_txd shows 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each held 234 cycles.
- Write 3 bytes quickly with tx_enable=0 (CTRL=8'h00), then read 16'h0102 → 8'h03. Read 16'h0101 → 8'h00. Then write CTRL=8'h01 → three frames with 1-cycle gaps. Final STATUS read → 8'h02.
- Push 17 bytes with tx_enable=0 → COUNT=8'h10, STATUS=8'h09 (overflow, full). Write STATUS=8'h08 → STATUS=8'h01.
- Start a frame, write CTRL=8'h02 (flush) mid-frame with 5 queued bytes → COUNT=0 next read. Current frame completes; no further frames.
- Access 16'h0104 with cyc/stb held 20 cycles → wb_ack_o stays 0 and no state change. Assert rst mid-frame → uart_txd=1 immediately and COUNT=0 after release.
- With WB_UART_TX_IRQ_EN: CTRL=8'h05, send 1 byte → irq low during frame, high 1 cycle after return to IDLE with empty FIFO.
